// File: rtl/hist_builder_rmw.sv
// hist_builder_rmw
// Builds per-pixel timestamp histograms in an external synchronous RAM.
// Each accepted hit is handled as a read-modify-write over three stages:
// read request, increment, write back. Same-address hits one or two slots
// apart are forwarded so that back-to-back hits count exactly.
// A build clears the RAM, accumulates ACQ_NUM frames, drains the pipeline
// and then pulses his_done for one cycle.

module hist_builder_rmw #(
  parameter int NB      = 8,  // bin-index width, 2**NB bins per pixel
  parameter int PIX_W   = 2,  // pixel-index width, 2**PIX_W pixels per RAM
  parameter int CNT_W   = 8,  // bin counter width
  parameter int ACQ_NUM = 4   // frames accumulated per build, >= 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic                  ts_valid,
  output logic                  ts_ready,
  input  logic [NB-1:0]         ts_bin,
  input  logic [PIX_W-1:0]      ts_pix,
  input  logic                  frame_end,
  output logic [PIX_W+NB-1:0]   raddr,
  output logic                  ren,
  input  logic [CNT_W-1:0]      rdata,
  output logic [PIX_W+NB-1:0]   waddr,
  output logic                  wen,
  output logic [CNT_W-1:0]      wdata,
  output logic                  busy,
  output logic                  sat_flag,
  output logic                  his_done
);

  localparam int AW    = PIX_W + NB;
  localparam int DEPTH = 2 ** AW;
  localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [ACQ_W-1:0] ACQ_LAST  = ACQ_W'(ACQ_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } stateT;

  stateT state, nextState;

  // Clear sweep address and frame counter
  logic [AW-1:0]    clrAddr;
  logic [ACQ_W-1:0] acqCnt;

  // Stage 2: hit whose read data arrives this cycle
  logic             s2Valid;
  logic [AW-1:0]    s2Addr;

  // Stage 3: write-back register, drives the RAM write port this cycle
  logic             s3Valid;
  logic [AW-1:0]    s3Addr;
  logic [CNT_W-1:0] s3Data;

  // Previous write: what the RAM was given last cycle (read-first RAM has
  // not yet shown it to a read issued in that same cycle)
  logic             pwValid;
  logic [AW-1:0]    pwAddr;
  logic [CNT_W-1:0] pwData;

  // Control decodes and increment datapath
  logic             startBuild;
  logic             accept;
  logic             lastFrame;
  logic [CNT_W-1:0] oldCnt;
  logic [CNT_W-1:0] newCnt;
  logic             satHit;

  // State register
  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers sample their inputs from the same edge; blocking assignments
  // here would make results depend on process evaluation order.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic and control outputs
  // NOTE: every signal written here gets a default at the top, so no path
  // through the case statement leaves one unassigned and infers a latch.
  always_comb begin
    nextState  = state;
    ts_ready   = 1'b0;
    busy       = 1'b1;
    his_done   = 1'b0;
    startBuild = 1'b0;
    lastFrame  = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          startBuild = 1'b1;
          nextState  = CLEAR;
        end
      end
      CLEAR: begin
        if (clrAddr == LAST_ADDR) begin
          nextState = ACCUM;
        end
      end
      ACCUM: begin
        ts_ready = 1'b1;
        if (frame_end && (acqCnt == ACQ_LAST)) begin
          lastFrame = 1'b1;
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        // Stage 3 completes its write during this cycle, so only the two
        // earlier stages need to be empty before leaving.
        if (!s1Pending() && !s2Valid) begin
          nextState = DONE;
        end
      end
      DONE: begin
        his_done  = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // The read-request stage is the registered ren output itself.
  function automatic logic s1Pending();
    return ren;
  endfunction

  assign accept = ts_valid & ts_ready;

  // Clear sweep address and acquisition counter
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      clrAddr <= '0;
      acqCnt  <= '0;
    end else begin
      if (startBuild) begin
        clrAddr <= '0;
        acqCnt  <= '0;
      end else if (state == CLEAR) begin
        clrAddr <= clrAddr + 1'b1;
      end

      if ((state == ACCUM) && frame_end && !lastFrame) begin
        acqCnt <= acqCnt + 1'b1;
      end
    end
  end

  // Stage 1: register the accepted hit as the RAM read request
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ren   <= 1'b0;
      raddr <= '0;
    end else begin
      ren <= accept;
      if (accept) begin
        raddr <= {ts_pix, ts_bin};
      end
    end
  end

  // Stage 2: the read data for this hit is on rdata during this stage
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s2Valid <= 1'b0;
      s2Addr  <= '0;
    end else begin
      s2Valid <= ren;
      s2Addr  <= raddr;
    end
  end

  // Old count selection: the nearest pending write to the same bin wins
  always_comb begin
    oldCnt = rdata;
    if (s3Valid && (s3Addr == s2Addr)) begin
      oldCnt = s3Data;
    end else if (pwValid && (pwAddr == s2Addr)) begin
      oldCnt = pwData;
    end
    satHit = (oldCnt == CNT_MAX);
    newCnt = satHit ? CNT_MAX : (oldCnt + 1'b1);
  end

  // Stage 3 and previous-write registers
  // NOTE: reset covers only the pipeline registers; the histogram RAM itself
  // is never reset, it is zeroed by the CLEAR sweep at the start of a build.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s3Valid <= 1'b0;
      s3Addr  <= '0;
      s3Data  <= '0;
      pwValid <= 1'b0;
      pwAddr  <= '0;
      pwData  <= '0;
    end else begin
      s3Valid <= s2Valid;
      if (s2Valid) begin
        s3Addr <= s2Addr;
        s3Data <= newCnt;
      end
      pwValid <= s3Valid;
      pwAddr  <= s3Addr;
      pwData  <= s3Data;
    end
  end

  // Sticky saturation flag, cleared when a new build starts
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sat_flag <= 1'b0;
    end else if (startBuild) begin
      sat_flag <= 1'b0;
    end else if (s2Valid && satHit) begin
      sat_flag <= 1'b1;
    end
  end

  // RAM write port: the clear sweep owns it in CLEAR, stage 3 otherwise
  always_comb begin
    wen   = s3Valid;
    waddr = s3Addr;
    wdata = s3Data;
    if (state == CLEAR) begin
      wen   = 1'b1;
      waddr = clrAddr;
      wdata = '0;
    end
  end

endmodule

// File: tb/tb_hist_builder_rmw.sv
// Directed testbench for hist_builder_rmw with a behavioural read-first RAM.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_hist_builder_rmw;

  localparam int NB      = 2;
  localparam int PIX_W   = 1;
  localparam int CNT_W   = 3;
  localparam int ACQ_NUM = 2;
  localparam int AW      = PIX_W + NB;
  localparam int DEPTH   = 2 ** AW;

  logic             clk = 1'b0;
  logic             res;
  logic             start;
  logic             ts_valid;
  logic             ts_ready;
  logic [NB-1:0]    ts_bin;
  logic [PIX_W-1:0] ts_pix;
  logic             frame_end;
  logic [AW-1:0]    raddr;
  logic             ren;
  logic [CNT_W-1:0] rdata = '0;
  logic [AW-1:0]    waddr;
  logic             wen;
  logic [CNT_W-1:0] wdata;
  logic             busy;
  logic             sat_flag;
  logic             his_done;

  // Garbage initial contents so the clear sweep is actually exercised
  logic [CNT_W-1:0] mem [DEPTH] = '{default: 3'd5};

  int compared   = 0;
  int mismatched = 0;
  int wenCount   = 0;
  int doneCount  = 0;

  always #5 clk = ~clk;

  hist_builder_rmw #(
    .NB(NB), .PIX_W(PIX_W), .CNT_W(CNT_W), .ACQ_NUM(ACQ_NUM)
  ) dut (
    .clk(clk), .res(res), .start(start),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_bin(ts_bin), .ts_pix(ts_pix),
    .frame_end(frame_end),
    .raddr(raddr), .ren(ren), .rdata(rdata),
    .waddr(waddr), .wen(wen), .wdata(wdata),
    .busy(busy), .sat_flag(sat_flag), .his_done(his_done)
  );

  // Read-first synchronous RAM: rdata valid the cycle after ren
  always @(posedge clk) begin
    if (ren) rdata <= mem[raddr];
    if (wen) mem[waddr] <= wdata;
  end

  // Event counters sampled at the active edge
  always @(posedge clk) begin
    if (wen === 1'b1) wenCount <= wenCount + 1;
    if (his_done === 1'b1) doneCount <= doneCount + 1;
  end

  // Start a build and verify the clear sweep, ending in the first ACCUM cycle
  task automatic runClear(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compared++;
    if (sat_flag !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL %s clear_entry sat_flag=%b busy=%b required 0/1", tag, sat_flag, busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      compared++;
      if (wen !== 1'b1 || waddr !== AW'(i) || wdata !== '0 || ts_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL %s clear_%0d wen=%b waddr=%0d wdata=%0d ts_ready=%b required 1/%0d/0/0",
                 tag, i, wen, waddr, wdata, ts_ready, i);
      end
      @(negedge clk);
    end
    compared++;
    if (ts_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s ready_after_clear ts_ready=%b required 1", tag, ts_ready);
    end
  endtask

  task automatic hit(input logic [AW-1:0] addr);
    ts_valid = 1'b1;
    {ts_pix, ts_bin} = addr;
    @(negedge clk);
    ts_valid = 1'b0;
  endtask

  task automatic frameEnd();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  // Bounded wait for his_done, then confirm the return to IDLE
  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (his_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (his_done !== 1'b1) begin
      mismatched++;
      $display("FAIL %s done_timeout his_done=%b required 1", tag, his_done);
    end
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || his_done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s idle_after_done busy=%b his_done=%b required 0/0", tag, busy, his_done);
    end
  endtask

  task automatic test_reset();
    res = 1'b1; start = 1'b0; ts_valid = 1'b0; frame_end = 1'b0;
    ts_bin = '0; ts_pix = '0;
    repeat (2) @(negedge clk);
    compared++;
    if ({ren, wen, ts_ready, busy, sat_flag, his_done} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl ren/wen/rdy/busy/sat/done=%b required 000000",
               {ren, wen, ts_ready, busy, sat_flag, his_done});
    end
    compared++;
    if (raddr !== '0 || waddr !== '0 || wdata !== '0) begin
      mismatched++;
      $display("FAIL reset_bus raddr=%0d waddr=%0d wdata=%0d required 0", raddr, waddr, wdata);
    end
    res = 1'b0;
    // Hits and frame_end in IDLE must be ignored
    ts_valid = 1'b1; frame_end = 1'b1;
    compared++;
    if (ts_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_ready ts_ready=%b required 0", ts_ready);
    end
    @(negedge clk);
    ts_valid = 1'b0; frame_end = 1'b0;
    compared++;
    if (ren !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_ignore ren=%b busy=%b required 0/0", ren, busy);
    end
  endtask

  task automatic test_single_bin();
    logic [CNT_W-1:0] expMem [DEPTH];
    int d0;
    d0 = doneCount;
    runClear("single");
    repeat (5) hit(3'd6);
    frameEnd();
    compared++;
    if (ts_ready !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL single_first_frame ts_ready=%b busy=%b required 1/1", ts_ready, busy);
    end
    @(negedge clk);
    frameEnd();
    waitDone("single");
    expMem = '{default: '0};
    expMem[6] = 3'd5;
    for (int a = 0; a < DEPTH; a++) begin
      compared++;
      if (mem[a] !== expMem[a]) begin
        mismatched++;
        $display("FAIL single_mem[%0d] got=%0d required %0d", a, mem[a], expMem[a]);
      end
    end
    compared++;
    if (doneCount - d0 !== 1 || sat_flag !== 1'b0) begin
      mismatched++;
      $display("FAIL single_done_pulses got=%0d sat=%b required 1/0", doneCount - d0, sat_flag);
    end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] expMem [DEPTH];
    runClear("b2b");
    // start while in ACCUM must not restart the build
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit(3'd3); hit(3'd5); hit(3'd3); hit(3'd3); hit(3'd5);
    frameEnd();
    frameEnd();
    waitDone("b2b");
    expMem = '{default: '0};
    expMem[3] = 3'd3;
    expMem[5] = 3'd2;
    for (int a = 0; a < DEPTH; a++) begin
      compared++;
      if (mem[a] !== expMem[a]) begin
        mismatched++;
        $display("FAIL b2b_mem[%0d] got=%0d required %0d", a, mem[a], expMem[a]);
      end
    end
    compared++;
    if (sat_flag !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_sat sat_flag=%b required 0", sat_flag);
    end
  endtask

  task automatic test_saturation();
    runClear("sat");
    repeat (7) hit(3'd0);
    repeat (4) @(negedge clk);
    compared++;
    if (mem[0] !== 3'd7 || sat_flag !== 1'b0) begin
      mismatched++;
      $display("FAIL sat_at_max mem0=%0d sat=%b required 7/0", mem[0], sat_flag);
    end
    repeat (2) hit(3'd0);
    repeat (3) @(negedge clk);
    compared++;
    if (sat_flag !== 1'b1) begin
      mismatched++;
      $display("FAIL sat_set sat_flag=%b required 1", sat_flag);
    end
    frameEnd();
    frameEnd();
    waitDone("sat");
    repeat (3) @(negedge clk);
    compared++;
    if (mem[0] !== 3'd7 || sat_flag !== 1'b1) begin
      mismatched++;
      $display("FAIL sat_final mem0=%0d sat=%b required 7/1", mem[0], sat_flag);
    end
  endtask

  task automatic test_frame_end_hit();
    hitDoneCheck: begin
      runClear("fe");
      hit(3'd1);
      frameEnd();
      repeat (2) @(negedge clk);
      ts_valid = 1'b1; {ts_pix, ts_bin} = 3'd2; frame_end = 1'b1;
      @(negedge clk);
      ts_valid = 1'b0; frame_end = 1'b0;
      compared++;
      if (ts_ready !== 1'b0 || busy !== 1'b1 || his_done !== 1'b0) begin
        mismatched++;
        $display("FAIL fe_drain_entry ts_ready=%b busy=%b his_done=%b required 0/1/0",
                 ts_ready, busy, his_done);
      end
      @(negedge clk);
      compared++;
      if (his_done !== 1'b0) begin
        mismatched++;
        $display("FAIL fe_drain2 his_done=%b required 0", his_done);
      end
      @(negedge clk);
      compared++;
      if (his_done !== 1'b0 || wen !== 1'b1 || waddr !== 3'd2 || wdata !== 3'd1) begin
        mismatched++;
        $display("FAIL fe_last_write his_done=%b wen=%b waddr=%0d wdata=%0d required 0/1/2/1",
                 his_done, wen, waddr, wdata);
      end
      @(negedge clk);
      compared++;
      if (his_done !== 1'b1) begin
        mismatched++;
        $display("FAIL fe_done_cycle his_done=%b required 1", his_done);
      end
      @(negedge clk);
      compared++;
      if (his_done !== 1'b0 || busy !== 1'b0 || mem[1] !== 3'd1 || mem[2] !== 3'd1) begin
        mismatched++;
        $display("FAIL fe_final his_done=%b busy=%b mem1=%0d mem2=%0d required 0/0/1/1",
                 his_done, busy, mem[1], mem[2]);
      end
    end
  endtask

  task automatic test_reset_midbuild();
    int w0;
    runClear("rst");
    ts_valid = 1'b1; {ts_pix, ts_bin} = 3'd4;
    repeat (3) @(negedge clk);
    res = 1'b1;
    #1;
    compared++;
    if ({ren, wen, ts_ready, busy, sat_flag, his_done} !== 6'b0 ||
        raddr !== '0 || waddr !== '0 || wdata !== '0) begin
      mismatched++;
      $display("FAIL rst_outputs ctrl=%b raddr=%0d waddr=%0d wdata=%0d required 0",
               {ren, wen, ts_ready, busy, sat_flag, his_done}, raddr, waddr, wdata);
    end
    w0 = wenCount;
    @(negedge clk);
    res = 1'b0; ts_valid = 1'b0;
    repeat (5) @(negedge clk);
    compared++;
    if (wenCount !== w0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_no_writes writes=%0d busy=%b required 0/0", wenCount - w0, busy);
    end
    runClear("rst_again");
    frameEnd();
    frameEnd();
    waitDone("rst_again");
    for (int a = 0; a < DEPTH; a++) begin
      compared++;
      if (mem[a] !== '0) begin
        mismatched++;
        $display("FAIL rst_mem[%0d] got=%0d required 0", a, mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bin();
    test_back_to_back();
    test_saturation();
    test_frame_end_hit();
    test_reset_midbuild();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hist_builder_rmw.md
HIST_BUILDER_RMW -- requirements
Module: hist_builder_rmw

Interface
REQ-001 SHALL have parameter NB, default 8, bin-index width; bins per pixel histogram = 2**NB.
REQ-002 SHALL have parameter PIX_W, default 2, pixel-index width; pixels per RAM = 2**PIX_W.
REQ-003 SHALL have parameter CNT_W, default 8, bin counter width.
REQ-004 SHALL have parameter ACQ_NUM, default 4, acquisitions (frames) accumulated per histogram build, >=1.
REQ-005 SHALL have derived localparam AW = PIX_W+NB, RAM address width; DEPTH = 2**AW.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port res  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  input  1  one-cycle pulse, begin a build (sampled in IDLE only).
REQ-009 SHALL have port ts_valid  input  1  timestamp hit valid.
REQ-010 SHALL have port ts_ready  output  1  hit accepted when ts_valid & ts_ready at rising edge.
REQ-011 SHALL have port ts_bin  input  NB  bin index of hit.
REQ-012 SHALL have port ts_pix  input  PIX_W  pixel index of hit.
REQ-013 SHALL have port frame_end  input  1  one-cycle pulse, end of current acquisition.
REQ-014 SHALL have ports raddr  output  AW, ren  output  1  RAM read port; rdata  input  CNT_W, valid the cycle after ren.
REQ-015 SHALL have ports waddr  output  AW, wen  output  1, wdata  output  CNT_W  RAM write port.
REQ-016 SHALL have port busy  output  1  high in any state but IDLE.
REQ-017 SHALL have port sat_flag  output  1  sticky: some bin saturated this build.
REQ-018 SHALL have port his_done  output  1  one-cycle pulse, histogram complete.

Function
REQ-019 SHALL implement states IDLE, CLEAR, ACCUM, DRAIN, DONE.
REQ-020 IDLE->CLEAR on start; CLEAR->ACCUM after address DEPTH-1 written; ACCUM->DRAIN on frame_end when acq counter = ACQ_NUM-1; DRAIN->DONE when pipeline empty; DONE->IDLE after one cycle.
REQ-021 CLEAR SHALL write wdata=0 to addresses 0..DEPTH-1, one per cycle, ascending; clears sat_flag and acq counter on entry.
REQ-022 ts_ready SHALL be 1 only in ACCUM; hits while not ready are ignored.
REQ-023 RAM address of hit SHALL be {ts_pix, ts_bin}.
REQ-024 Hit accepted at edge t: ren=1, raddr=addr during cycle t+1; rdata used in cycle t+2; wen=1, waddr=addr, wdata=new count during cycle t+3.
REQ-025 Accepts one hit per cycle at full throughput, no stalls.
REQ-026 New count = old+1, saturating at 2**CNT_W-1; increment at max SHALL write max and set sat_flag.
REQ-027 RAM read-during-write is read-first; block SHALL forward: old value taken from the write-stage register if same address (hit distance 1), else from the previous-write register if same address (distance 2), else rdata.
REQ-028 Any interleaving of same-address hits SHALL yield exact final count (saturation excepted).
REQ-029 frame_end in ACCUM increments acq counter; a hit accepted on the same edge SHALL be counted in the ending frame.
REQ-030 DRAIN SHALL last until the last accepted hit's write completes (3 cycles after last acceptance); no new hits accepted.
REQ-031 his_done SHALL be 1 exactly in DONE cycle; busy=0 in IDLE.
REQ-032 start outside IDLE and frame_end outside ACCUM SHALL be ignored.

Reset
REQ-033 res=1 SHALL force IDLE asynchronously; ren, wen, ts_ready, busy, sat_flag, his_done, raddr, waddr, wdata, acq counter, pipeline valids = 0.
REQ-034 Reset mid-build SHALL abort with no further RAM writes; RAM contents undefined until next start's CLEAR.

Verification (NB=2, PIX_W=1, CNT_W=3, ACQ_NUM=2, DEPTH=8)
REQ-035 start -> 8 cycles wen=1, waddr 0..7, wdata 0, then ts_ready=1.
REQ-036 Hits (pix1,bin2) on 5 consecutive cycles, frame_end x2 -> addr 6 final 5, all others 0, his_done pulse once.
REQ-037 Hit pattern addr 3,5,3,3,5 back-to-back -> addr3=3, addr5=2 (forwarding distances 1 and 2).
REQ-038 9 hits to addr 0 -> addr0=7, sat_flag=1 until next start.
REQ-039 frame_end coincident with hit on 2nd frame -> hit counted, ts_ready drops next cycle, his_done 4 cycles after.
REQ-040 res pulse during ACCUM with hits in flight -> all outputs 0 next cycle, no wen afterwards, next start clears all 8 addresses.
